// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-voted bits, parity/framing/break flags per word,
// and a small show-ahead FIFO drained through a valid/ready port.
module uart_rx_os #(
  parameter int CLK_HZ       = 120_000_000,
  parameter int BIT_RATE     = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  localparam int LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_parity_err,
  output logic                    rx_frame_err,
  output logic                    rx_break,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic                    rx_overrun,
  output logic [LVL_W-1:0]        rx_level
);

  localparam int TICK_RAW = CLK_HZ / (BIT_RATE * OVERSAMPLE);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_W     = $clog2(OVERSAMPLE);
  localparam int BC_W     = $clog2(PAYLOAD_BITS + 1);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int WORD_W   = PAYLOAD_BITS + 3;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_S0    = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0]  PH_S1    = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVERSAMPLE / 2 + 1);
  localparam logic [BC_W-1:0]  BC_FULL  = BC_W'(PAYLOAD_BITS);
  localparam logic             SC_LAST  = 1'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
  } state_t;

  logic                    rxd_meta_q, rxd_q;
  logic [DIV_W-1:0]        div_q;
  logic [PH_W-1:0]         ph_q;
  logic                    samp0_q, samp1_q;
  state_t                  state_q;
  logic [BC_W-1:0]         bit_cnt_q;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    par_q, ferr_q, stop_zero_q, stop_cnt_q;

  logic tick, mid, wrap, vote, push, brk_w, ferr_w, perr_w;
  logic [WORD_W-1:0] word_w;

  // Disabling forces the synchroniser to idle-high so no false start is seen on re-enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta_q <= 1'b1;
      rxd_q      <= 1'b1;
    end else if (uart_rx_en) begin
      rxd_meta_q <= uart_rxd;
      rxd_q      <= rxd_meta_q;
    end else begin
      rxd_meta_q <= 1'b1;
      rxd_q      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                div_q <= '0;
    else if (!uart_rx_en)       div_q <= '0;
    else if (div_q == DIV_LAST) div_q <= '0;
    else                        div_q <= div_q + DIV_W'(1);
  end

  assign tick = uart_rx_en && (div_q == DIV_LAST);
  assign mid  = tick && (ph_q == PH_MID);
  assign wrap = tick && (ph_q == PH_LAST);
  assign vote = (samp0_q & samp1_q) | (samp0_q & rxd_q) | (samp1_q & rxd_q);

  always_comb begin
    perr_w = 1'b0;
    if (PARITY == 1)      perr_w = ^{shift_q, par_q};
    else if (PARITY == 2) perr_w = ~^{shift_q, par_q};
  end

  // The last stop bit's vote is folded in combinationally so the push lands on its mid point.
  assign brk_w  = ~|shift_q & ((PARITY == 0) || !par_q) & stop_zero_q & ~vote;
  assign ferr_w = ferr_q | ~vote;
  assign word_w = {brk_w, ferr_w, perr_w, shift_q};
  assign push   = (state_q == ST_STOP) && mid && (stop_cnt_q == SC_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      samp0_q     <= 1'b0;
      samp1_q     <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ferr_q      <= 1'b0;
      stop_zero_q <= 1'b0;
      stop_cnt_q  <= 1'b0;
    end else if (!uart_rx_en) begin
      state_q    <= ST_IDLE;
      ph_q       <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      if (tick) ph_q <= (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
      if (tick && ph_q == PH_S0) samp0_q <= rxd_q;
      if (tick && ph_q == PH_S1) samp1_q <= rxd_q;
      case (state_q)
        ST_IDLE: begin
          if (!rxd_q) begin
            state_q     <= ST_START;
            ph_q        <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            ferr_q      <= 1'b0;
            stop_zero_q <= 1'b1;
          end
        end
        ST_START: begin
          if (mid && vote) state_q <= ST_IDLE;
          else if (wrap)   state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (mid) begin
            shift_q   <= {vote, shift_q[PAYLOAD_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BC_W'(1);
          end
          if (wrap && bit_cnt_q == BC_FULL)
            state_q <= (PARITY != 0) ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (mid)  par_q   <= vote;
          if (wrap) state_q <= ST_STOP;
        end
        ST_STOP: begin
          if (mid) begin
            if (!vote) ferr_q <= 1'b1;
            stop_zero_q <= stop_zero_q & ~vote;
            if (stop_cnt_q == SC_LAST) state_q <= brk_w ? ST_WAIT_HIGH : ST_IDLE;
            else                       stop_cnt_q <= 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (rxd_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overrun_q, full, pop, push_ok;
  logic [WORD_W-1:0] head;

  assign rx_valid = (level_q != '0);
  assign full     = (level_q == LVL_FULL);
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push && (!full || pop);

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push_ok && pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= word_w;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q   <= level_d;
      overrun_q <= push && full && !pop;
    end
  end

  // Head is gated by occupancy so an empty FIFO presents all-zero data and flags.
  assign head          = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign rx_data       = head[PAYLOAD_BITS-1:0];
  assign rx_parity_err = head[PAYLOAD_BITS];
  assign rx_frame_err  = head[PAYLOAD_BITS+1];
  assign rx_break      = head[PAYLOAD_BITS+2];
  assign rx_overrun    = overrun_q;
  assign rx_level      = level_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: 8N1 and 8E1 instances, scoreboard of expected words.
module tb_uart_rx_os;
  localparam int LVL_W = $clog2(4 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, rxd, rxd_p, rx_en, rx_ready, ready_p;
  logic [7:0] rx_data, rx_data_p;
  logic rx_parity_err, rx_frame_err, rx_break, rx_valid, rx_overrun;
  logic rx_parity_err_p, rx_frame_err_p, rx_break_p, rx_valid_p, rx_overrun_p;
  logic [LVL_W-1:0] rx_level, rx_level_p;

  uart_rx_os #(.CLK_HZ(1_843_200), .BIT_RATE(115200), .OVERSAMPLE(16), .PAYLOAD_BITS(8),
               .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd), .uart_rx_en(rx_en),
    .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .rx_level(rx_level));

  uart_rx_os #(.CLK_HZ(1_843_200), .BIT_RATE(115200), .OVERSAMPLE(16), .PAYLOAD_BITS(8),
               .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_p (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_p), .uart_rx_en(rx_en),
    .rx_data(rx_data_p), .rx_parity_err(rx_parity_err_p), .rx_frame_err(rx_frame_err_p),
    .rx_break(rx_break_p), .rx_valid(rx_valid_p), .rx_ready(ready_p),
    .rx_overrun(rx_overrun_p), .rx_level(rx_level_p));

  logic [10:0] exp_q[$], got_q[$], exp_p_q[$], got_p_q[$];
  int n_checks = 0, n_pass = 0, ovr_cnt = 0, vld_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_break, rx_frame_err, rx_parity_err, rx_data});
    if (rx_valid_p && ready_p) got_p_q.push_back({rx_break_p, rx_frame_err_p, rx_parity_err_p, rx_data_p});
    if (rx_valid) vld_cnt++;
    if (rx_overrun) ovr_cnt++;
  end

  function automatic logic [10:0] mk(input logic brk, input logic ferr, input logic perr, input logic [7:0] d);
    return {brk, ferr, perr, d};
  endfunction

  // Each bit is held for exactly 16 clocks, LSB of 'bits' first.
  task automatic drive_bits(input logic [31:0] bits, input int n, input bit on_p);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      if (on_p) rxd_p = bits[i]; else rxd = bits[i];
      repeat (15) @(posedge clk);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic stop);
    drive_bits({22'd0, stop, d, 1'b0}, 10, 1'b0);
    drive_bits(32'hFFFF_FFFF, 2, 1'b0);
  endtask

  task automatic test_reset;
    resetn = 1'b0; rx_en = 1'b1; rxd = 1'b1; rxd_p = 1'b1; rx_ready = 1'b0; ready_p = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else n_pass++;
    n_checks++; if ({rx_break, rx_frame_err, rx_parity_err, rx_overrun} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {rx_break, rx_frame_err, rx_parity_err, rx_overrun}); else n_pass++;
    n_checks++; if (rx_level !== '0) $display("FAIL reset_level: got %0d want 0", rx_level); else n_pass++;
    @(posedge clk); #2 resetn = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL post_reset_valid: got %b want 0", rx_valid); else n_pass++;
  endtask

  task automatic test_8n1;
    logic [10:0] e, g;
    int v0;
    @(posedge clk); #2 rx_ready = 1'b1;
    v0 = vld_cnt;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'hA5));
    send8(8'hA5, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL 8n1_word: got none want %h", e);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL 8n1_word: got %h want %h", g, e); else n_pass++; end
    end
    @(negedge clk);
    n_checks++; if (vld_cnt - v0 !== 1) $display("FAIL 8n1_valid_cycles: got %0d want 1", vld_cnt - v0); else n_pass++;
    n_checks++; if (rx_level !== '0) $display("FAIL 8n1_level: got %0d want 0", rx_level); else n_pass++;
  endtask

  task automatic test_parity;
    logic [10:0] e, g;
    exp_p_q.push_back(mk(1'b0, 1'b0, 1'b1, 8'h03));
    drive_bits({21'd0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 1'b1);
    drive_bits(32'hFFFF_FFFF, 2, 1'b1);
    exp_p_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h03));
    drive_bits({21'd0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, 1'b1);
    drive_bits(32'hFFFF_FFFF, 2, 1'b1);
    while (exp_p_q.size() > 0) begin
      e = exp_p_q.pop_front();
      n_checks++;
      if (got_p_q.size() == 0) $display("FAIL parity_word: got none want %h", e);
      else begin g = got_p_q.pop_front(); if (g !== e) $display("FAIL parity_word: got %h want %h", g, e); else n_pass++; end
    end
  endtask

  task automatic test_frame_err;
    logic [10:0] e, g;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 8'h55));
    send8(8'h55, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL frame_word: got none want %h", e);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL frame_word: got %h want %h", g, e); else n_pass++; end
    end
    n_checks++; if (got_q.size() != 0) $display("FAIL frame_extra: got %0d extra want 0", got_q.size()); else n_pass++;
  endtask

  task automatic test_break;
    logic [10:0] e, g;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00));
    drive_bits(32'h0, 20, 1'b0);
    n_checks++; if (got_q.size() != 1) $display("FAIL break_count: got %0d entries want 1", got_q.size()); else n_pass++;
    drive_bits(32'hFFFF_FFFF, 2, 1'b0);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h7E));
    send8(8'h7E, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL break_word: got none want %h", e);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL break_word: got %h want %h", g, e); else n_pass++; end
    end
    n_checks++; if (got_q.size() != 0) $display("FAIL break_extra: got %0d extra want 0", got_q.size()); else n_pass++;
  endtask

  task automatic test_fifo_overrun;
    logic [10:0] e, g;
    int o0;
    @(posedge clk); #2 rx_ready = 1'b0;
    o0 = ovr_cnt;
    for (int k = 0; k < 5; k++) begin
      send8(8'h11 + 8'(k), 1'b1);
      if (k < 4) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h11 + 8'(k)));
    end
    @(negedge clk);
    n_checks++; if (rx_level !== LVL_W'(4)) $display("FAIL fifo_level: got %0d want 4", rx_level); else n_pass++;
    n_checks++; if (ovr_cnt - o0 !== 1) $display("FAIL fifo_overrun: got %0d pulses want 1", ovr_cnt - o0); else n_pass++;
    n_checks++; if (rx_data !== 8'h11) $display("FAIL fifo_head: got %h want 11", rx_data); else n_pass++;
    @(posedge clk); #2 rx_ready = 1'b1;
    repeat (10) @(posedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL fifo_word: got none want %h", e);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL fifo_word: got %h want %h", g, e); else n_pass++; end
    end
    @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL fifo_drained: got valid %b want 0", rx_valid); else n_pass++;
  endtask

  task automatic test_glitch;
    @(posedge clk); #2 rxd = 1'b0;
    repeat (4) @(posedge clk);
    #2 rxd = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    n_checks++; if (got_q.size() != 0 || rx_level !== '0)
      $display("FAIL glitch: got %0d entries level %0d want 0", got_q.size(), rx_level); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [10:0] e, g;
    @(posedge clk); #2 rx_ready = 1'b0;
    send8(8'h21, 1'b1);
    send8(8'h22, 1'b1);
    @(negedge clk);
    n_checks++; if (rx_level !== LVL_W'(2)) $display("FAIL rstmid_level: got %0d want 2", rx_level); else n_pass++;
    drive_bits({22'd0, 1'b1, 8'h3C, 1'b0}, 4, 1'b0);
    #2 resetn = 1'b0;
    #1;
    n_checks++; if ({rx_valid, rx_level, rx_data} !== '0)
      $display("FAIL rstmid_outputs: got valid %b level %0d data %h want 0", rx_valid, rx_level, rx_data); else n_pass++;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1; rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h3C));
    send8(8'h3C, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL rstmid_word: got none want %h", e);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL rstmid_word: got %h want %h", g, e); else n_pass++; end
    end
  endtask

  task automatic test_disable;
    logic [10:0] e, g;
    logic [31:0] fr;
    fr = {22'd0, 1'b1, 8'h0F, 1'b0};
    drive_bits(fr, 4, 1'b0);
    #2 rx_en = 1'b0;
    drive_bits(fr >> 4, 6, 1'b0);
    drive_bits(32'hFFFF_FFFF, 2, 1'b0);
    #2 rx_en = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    n_checks++; if (got_q.size() != 0 || rx_level !== '0)
      $display("FAIL disable_drop: got %0d entries level %0d want 0", got_q.size(), rx_level); else n_pass++;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h5A));
    send8(8'h5A, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL disable_word: got none want %h", e);
      else begin g = got_q.pop_front(); if (g !== e) $display("FAIL disable_word: got %h want %h", g, e); else n_pass++; end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_break();
    test_fifo_overrun();
    test_glitch();
    test_reset_mid();
    test_disable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
